// File: rtl/postbox_pkg.sv
// Shared types and constants for the postbox host-link scheduler.
package postbox_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      GAP
   } state_e;

   typedef enum logic {
      GRANT_OUT,
      GRANT_IN
   } grant_e;

   localparam int unsigned SPI_BITS     = 8;
   localparam logic [7:0]  INPUT_DUMMY  = 8'h00;
   localparam logic [7:0]  TIMEOUT_BYTE = 8'hFF;

endpackage

// File: rtl/postbox_byte_fifo.sv
// Synchronous byte FIFO; DEPTH must be a power of two. Pop before push when full.
module postbox_byte_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign pop_data = mem[rd_ptr];

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/postbox_link_sched.sv
// Arbitrates the host SPI link between outbound FIFO bytes and inbound byte
// requests, drives an SPI mode-0 master and times out stalled input requests.
// Optional statistics counters: define POSTBOX_SCHED_STATS_EN.
module postbox_link_sched
   import postbox_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned GAP_CYCLES     = 2
) (
   input  logic        refclk,
   input  logic        reset_n,
   input  logic        out_valid,
   input  logic [7:0]  out_data,
   output logic        out_ready,
   input  logic        in_req,
   output logic        in_valid,
   output logic [7:0]  in_data,
   input  logic        rx_ready,
   input  logic        tx_pending,
   output logic        want_tx,
   output logic        xfer_is_input,
   output logic        spi_cs,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic        timeout_flag
`ifdef POSTBOX_SCHED_STATS_EN
  ,output logic [15:0] out_count,
   output logic [15:0] in_count,
   output logic [7:0]  to_count
`endif
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_e       state, state_d;
   grant_e       last_grant, last_grant_d;
   logic [2:0]   bit_cnt, bit_cnt_d;
   logic         phase, phase_d;
   logic [7:0]   gap_cnt, gap_cnt_d;
   logic [7:0]   shreg, shreg_d;
   logic         rx_bit, rx_bit_d;
   logic         is_in_d;
   logic         serviced, serviced_d;
   logic [7:0]   wait_cnt, wait_cnt_d;
   logic         in_valid_d;
   logic [7:0]   in_data_d;
   logic         timeout_d;
   logic         spi_cs_d, spi_sck_d, spi_mosi_d;
   logic         rdy_q;

   logic             fifo_full, fifo_empty, fifo_pop;
   logic [7:0]       fifo_head;
   logic [CNT_W-1:0] fifo_count;

   logic in_cand, out_cand, arb_ok, pick_in, pick_out, grant_in, to_fire;

   postbox_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (refclk),
      .reset_n   (reset_n),
      .push      (out_valid & out_ready),
      .push_data (out_data),
      .pop       (fifo_pop & ~fifo_empty),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign out_ready = rdy_q & ~fifo_full;
   assign want_tx   = rdy_q & in_req & ~serviced;

   // Grant decision: fair alternation on ties, also allowed on the last GAP cycle.
   assign in_cand  = in_req & tx_pending & ~serviced;
   assign out_cand = rx_ready & (fifo_count != '0);
   assign arb_ok   = (state == IDLE) | ((state == GAP) & (gap_cnt == 8'(GAP_CYCLES - 1)));
   assign pick_in  = in_cand & (~out_cand | (last_grant == GRANT_OUT));
   assign pick_out = out_cand & ~pick_in;
   assign grant_in = arb_ok & pick_in;
   assign to_fire  = in_req & ~serviced & ~grant_in & (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

   // State and registered outputs.
   always_ff @(posedge refclk) begin
      if (!reset_n) begin
         state         <= IDLE;
         last_grant    <= GRANT_OUT;
         bit_cnt       <= '0;
         phase         <= 1'b0;
         gap_cnt       <= '0;
         shreg         <= '0;
         rx_bit        <= 1'b0;
         xfer_is_input <= 1'b0;
         serviced      <= 1'b0;
         wait_cnt      <= '0;
         in_valid      <= 1'b0;
         in_data       <= '0;
         timeout_flag  <= 1'b0;
         spi_cs        <= 1'b1;
         spi_sck       <= 1'b0;
         spi_mosi      <= 1'b0;
         rdy_q         <= 1'b0;
      end else begin
         state         <= state_d;
         last_grant    <= last_grant_d;
         bit_cnt       <= bit_cnt_d;
         phase         <= phase_d;
         gap_cnt       <= gap_cnt_d;
         shreg         <= shreg_d;
         rx_bit        <= rx_bit_d;
         xfer_is_input <= is_in_d;
         serviced      <= serviced_d;
         wait_cnt      <= wait_cnt_d;
         in_valid      <= in_valid_d;
         in_data       <= in_data_d;
         timeout_flag  <= timeout_d;
         spi_cs        <= spi_cs_d;
         spi_sck       <= spi_sck_d;
         spi_mosi      <= spi_mosi_d;
         rdy_q         <= 1'b1;
      end
   end

   // Next-state, shifter, arbitration and timeout logic.
   always_comb begin
      state_d      = state;
      last_grant_d = last_grant;
      bit_cnt_d    = bit_cnt;
      phase_d      = phase;
      gap_cnt_d    = gap_cnt;
      shreg_d      = shreg;
      rx_bit_d     = rx_bit;
      is_in_d      = xfer_is_input;
      serviced_d   = serviced & in_req;
      wait_cnt_d   = '0;
      in_valid_d   = 1'b0;
      in_data_d    = in_data;
      timeout_d    = timeout_flag;
      fifo_pop     = 1'b0;

      unique case (state)
         SETUP: begin
            state_d   = SHIFT;
            phase_d   = 1'b0;
            bit_cnt_d = '0;
         end
         SHIFT: begin
            if (!phase) begin
               rx_bit_d = spi_miso;
               phase_d  = 1'b1;
            end else begin
               shreg_d = {shreg[6:0], rx_bit};
               phase_d = 1'b0;
               if (bit_cnt == 3'(SPI_BITS - 1)) begin
                  state_d   = GAP;
                  gap_cnt_d = '0;
                  is_in_d   = 1'b0;
                  if (xfer_is_input) begin
                     in_valid_d = 1'b1;
                     in_data_d  = {shreg[6:0], rx_bit};
                  end
               end else begin
                  bit_cnt_d = bit_cnt + 3'd1;
               end
            end
         end
         GAP: begin
            gap_cnt_d = gap_cnt + 8'd1;
            if (gap_cnt == 8'(GAP_CYCLES - 1)) state_d = IDLE;
         end
         default: ;
      endcase

      if (arb_ok & (pick_in | pick_out)) begin
         state_d      = SETUP;
         last_grant_d = pick_in ? GRANT_IN : GRANT_OUT;
         is_in_d      = pick_in;
         shreg_d      = pick_in ? INPUT_DUMMY : fifo_head;
         fifo_pop     = pick_out;
         if (pick_in) serviced_d = 1'b1;
      end

      if (to_fire) begin
         in_valid_d = 1'b1;
         in_data_d  = TIMEOUT_BYTE;
         timeout_d  = 1'b1;
         serviced_d = 1'b1;
      end else if (in_req & ~serviced & ~grant_in) begin
         wait_cnt_d = wait_cnt + 8'd1;
      end

      spi_cs_d   = ~((state_d == SETUP) | (state_d == SHIFT));
      spi_sck_d  = (state_d == SHIFT) & ~phase_d;
      spi_mosi_d = spi_cs_d ? 1'b0 : shreg_d[7];
   end

`ifdef POSTBOX_SCHED_STATS_EN
   logic xfer_end;
   assign xfer_end = (state == SHIFT) & phase & (bit_cnt == 3'(SPI_BITS - 1));

   // Saturating transfer and timeout counters.
   always_ff @(posedge refclk) begin
      if (!reset_n) begin
         out_count <= '0;
         in_count  <= '0;
         to_count  <= '0;
      end else begin
         if (xfer_end & ~xfer_is_input & (out_count != '1)) out_count <= out_count + 16'd1;
         if (xfer_end & xfer_is_input & (in_count != '1))   in_count  <= in_count + 16'd1;
         if (to_fire & (to_count != '1))                    to_count  <= to_count + 8'd1;
      end
   end
`endif

endmodule

// File: doc/postbox_link_sched.md
Name: postbox_link_sched

Overview:
- Schedules the single host SPI link between two requesters: outbound bytes from the target (OUTPUT/POST stream) and inbound byte requests (INPUT command, want_tx).
- Buffers outbound bytes in a small FIFO and arbitrates fairly between the two requesters.
- Generates the SPI master waveform (mode 0, MSB first) and times out stalled input requests.
- Sits between the postbox core and the CPLD pins that go to the host microcontroller.

Parameters:
- FIFO_DEPTH, 4, outbound byte FIFO entries (power of 2, ≥2).
- TIMEOUT_CYCLES, 255, refclk cycles an input request may wait for tx_pending before it is abandoned.
- GAP_CYCLES, 2, cycles spi_cs stays high between transfers.

Ports:
- refclk  in  1  2MHz system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- out_valid  in  1  postbox core has an outbound byte.
- out_data  in  8  outbound byte.
- out_ready  out  1  FIFO not full; a push occurs on out_valid & out_ready.
- in_req  in  1  core requests an input byte; level, held until in_valid.
- in_valid  out  1  one-cycle pulse; in_data is valid.
- in_data  out  8  received byte, or 8'hFF on timeout.
- rx_ready  in  1  host can accept a byte.
- tx_pending  in  1  host has a byte to send.
- want_tx  out  1  mirrors in_req while an input request is outstanding.
- xfer_is_input  out  1  1 while spi_cs is low for an input transfer.
- spi_cs  out  1  active-low chip select.
- spi_sck  out  1  SPI clock; idles low.
- spi_mosi  out  1  SPI data out.
- spi_miso  in  1  SPI data in.
- timeout_flag  out  1  sticky; set on any input timeout, cleared only by reset.

Behaviour:
- Reset (reset_n=0 at a refclk edge):
  - FIFO emptied; state IDLE.
  - Outputs: spi_cs=1, spi_sck=0, spi_mosi=0, in_valid=0, in_data=0, want_tx=0, xfer_is_input=0, timeout_flag=0, out_ready=0 during reset and 1 on the first cycle after.
  - Reset mid-transfer aborts immediately with no in_valid.
- States: IDLE, SETUP, SHIFT, GAP.
- IDLE grant rules, evaluated every cycle:
  - Input candidate: in_req & tx_pending.
  - Output candidate: FIFO non-empty & rx_ready.
  - Both candidates: grant goes to the type not granted last; last_grant resets to "output", so input wins the first tie.
  - On any grant, go to SETUP.
- SETUP (1 cycle):
  - spi_cs=0.
  - Shift register loaded: FIFO head (popped this cycle) for output; 8'h00 for input.
  - spi_mosi = bit7.
  - xfer_is_input set for input grants.
- SHIFT (16 cycles, bit counter 0..7):
  - Even phase: sck=1; miso sampled into shift LSB.
  - Odd phase: sck=0; shift left; mosi = new bit7.
  - After the 8th high phase and its following low phase, go to GAP.
- GAP (GAP_CYCLES):
  - spi_cs=1, xfer_is_input=0.
  - For input transfers, in_valid pulses on the first GAP cycle with in_data = captured byte.
  - Then return to IDLE.
- Total per byte: 1 + 16 + GAP_CYCLES cycles.
- Timeout:
  - 8-bit wait counter runs while in_req=1 and no input grant has been made.
  - When it reaches TIMEOUT_CYCLES: in_valid pulses with in_data=8'hFF, timeout_flag sets, counter clears, and in_req is treated as serviced.
  - The core must drop in_req the cycle after in_valid.
  - The counter is held at 0 while in_req=0.
- FIFO:
  - Push and pop in the same cycle are allowed, including when full, because the pop precedes the next-cycle out_ready update. out_ready is combinational (!full).
  - Pushes while full are impossible by handshake.
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- Handshake input changes: rx_ready/tx_pending falling after a grant do not abort the transfer.
- want_tx = in_req & ~serviced.

Optional Feature:
- Macro POSTBOX_SCHED_STATS_EN. When defined, adds three outputs:
  - out_count[15:0]: completed output transfers.
  - in_count[15:0]: completed input transfers.
  - to_count[7:0]: timeouts.
- All three are saturating and reset to 0.
- When undefined, the ports and counters are absent and other behaviour is identical.

Decomposition:
- Shared package postbox_pkg holds:
  - State enum (IDLE, SETUP, SHIFT, GAP).
  - Constants SPI_BITS=8, INPUT_DUMMY=8'h00, TIMEOUT_BYTE=8'hFF.
  - Grant-type enum (GRANT_OUT, GRANT_IN).
- Sub-module postbox_byte_fifo: synchronous FIFO with parameterised depth, push/pop/full/empty/count.

Test Plan:
- Push 8'hA5 with rx_ready=1 → spi_cs low 17 cycles; mosi bits on sck rising edges read 1,0,1,0,0,1,0,1; out_ready stays 1.
- Hold rx_ready=0 and push 5 bytes with FIFO_DEPTH=4 → out_ready=0 after the 4th push. Raise rx_ready → 4 transfers in push order, each 19 cycles apart.
- Hold in_req=1, tx_pending=1, miso driving 8'h3C → in_valid pulses once with in_data=8'h3C on the first GAP cycle; mosi all 0; xfer_is_input=1 during cs low.
- Two queued output bytes while in_req & tx_pending are held → grant order input, output, input.
- Hold in_req=1 with tx_pending=0 for 255 cycles → in_valid with 8'hFF and timeout_flag=1; spi_cs never asserted.
- Assert reset_n=0 at SHIFT bit 3 → next cycle spi_cs=1, sck=0, FIFO empty, no in_valid.
